riscv_sc_top: RTL and testbench

//  Top level of a single-cycle RV32I-subset processor system: core + instruction ROM + data RAM.

---
 rtl/riscv_pkg.sv | 85 ++++++++
 rtl/riscv_core.sv | 154 +++++++++++++++
 rtl/riscv_sc_top.sv | 54 +++++
 tb/tb_riscv_sc_top.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared opcodes, control enums and embedded program images
package riscv_pkg;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_op_t;

  typedef enum logic [1:0] {
    IMM_I = 2'd0,
    IMM_S = 2'd1,
    IMM_B = 2'd2,
    IMM_J = 2'd3
  } imm_src_t;

  typedef enum logic [1:0] {
    RES_ALU = 2'd0,
    RES_MEM = 2'd1,
    RES_PC4 = 2'd2
  } result_src_t;

  // Program images that can be baked into the instruction ROM, selected by name.
  localparam int PROG_RISCVTEST = 0;
  localparam int PROG_X0TEST    = 1;
  localparam int PROG_SLTTEST   = 2;

  // Word idx of the selected image; unused locations read as 0 (a no-op opcode).
  function automatic logic [31:0] rom_word(input int prog, input int idx);
    logic [31:0] w;
    w = 32'h0000_0000;
    if (prog == PROG_X0TEST) begin
      case (idx)
        0: w = 32'h0050_0013;  // addi x0,x0,5
        1: w = 32'h0000_2023;  // sw   x0,0(x0)
        2: w = 32'h0000_0063;  // beq  x0,x0,0
        default: w = 32'h0000_0000;
      endcase
    end else if (prog == PROG_SLTTEST) begin
      case (idx)
        0: w = 32'hFFF0_0093;  // addi x1,x0,-1
        1: w = 32'h0000_A133;  // slt  x2,x1,x0
        2: w = 32'h0020_2423;  // sw   x2,8(x0)
        3: w = 32'h0000_0063;  // beq  x0,x0,0
        default: w = 32'h0000_0000;
      endcase
    end else begin
      case (idx)
        0:  w = 32'h0050_0113;  // addi x2,x0,5
        1:  w = 32'h00C0_0193;  // addi x3,x0,12
        2:  w = 32'hFF71_8393;  // addi x7,x3,-9
        3:  w = 32'h0023_E233;  // or   x4,x7,x2
        4:  w = 32'h0041_F2B3;  // and  x5,x3,x4
        5:  w = 32'h0042_82B3;  // add  x5,x5,x4
        6:  w = 32'h0272_8863;  // beq  x5,x7,end
        7:  w = 32'h0041_A233;  // slt  x4,x3,x4
        8:  w = 32'h0002_0463;  // beq  x4,x0,around
        9:  w = 32'h0000_0293;  // addi x5,x0,0
        10: w = 32'h0023_A233;  // slt  x4,x7,x2
        11: w = 32'h0052_03B3;  // add  x7,x4,x5
        12: w = 32'h4023_83B3;  // sub  x7,x7,x2
        13: w = 32'h0471_AA23;  // sw   x7,84(x3)
        14: w = 32'h0600_2103;  // lw   x2,96(x0)
        15: w = 32'h0051_04B3;  // add  x9,x2,x5
        16: w = 32'h0080_01EF;  // jal  x3,end
        17: w = 32'h0010_0113;  // addi x2,x0,1
        18: w = 32'h0091_0133;  // add  x2,x2,x9
        19: w = 32'h0221_A023;  // sw   x2,0x20(x3)
        20: w = 32'h0021_0063;  // beq  x2,x2,done
        default: w = 32'h0000_0000;
      endcase
    end
    return w;
  endfunction

endpackage

// File: rtl/riscv_core.sv
// rtl/riscv_core.sv - single-cycle RV32I-subset controller, datapath and register file
module riscv_core
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic [31:0] readdata,
  output logic [31:0] pc,
  output logic        memwrite,
  output logic [31:0] aluresult,
  output logic [31:0] writedata
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rs1, rs2, rd;
  logic        regwrite, alusrc, branch, jump, zero;
  alu_op_t     alu_op;
  imm_src_t    imm_src;
  result_src_t result_src;
  logic [31:0] immext, srca, srcb, result;
  logic [31:0] pcplus4, pctarget, pcnext;
  logic [31:0] rf [32];

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign rd     = instr[11:7];

  // Main decoder: unsupported opcode/funct combinations fall through as no-ops.
  always_comb begin
    regwrite   = 1'b0;
    memwrite   = 1'b0;
    alusrc     = 1'b0;
    branch     = 1'b0;
    jump       = 1'b0;
    alu_op     = ALU_ADD;
    imm_src    = IMM_I;
    result_src = RES_ALU;
    case (opcode)
      OP_LW: begin
        if (funct3 == 3'b010) begin
          regwrite   = 1'b1;
          alusrc     = 1'b1;
          result_src = RES_MEM;
        end
      end
      OP_SW: begin
        if (funct3 == 3'b010) begin
          memwrite = 1'b1;
          alusrc   = 1'b1;
          imm_src  = IMM_S;
        end
      end
      OP_R: begin
        regwrite = 1'b1;
        case ({funct7, funct3})
          {7'h00, 3'b000}: alu_op = ALU_ADD;
          {7'h20, 3'b000}: alu_op = ALU_SUB;
          {7'h00, 3'b111}: alu_op = ALU_AND;
          {7'h00, 3'b110}: alu_op = ALU_OR;
          {7'h00, 3'b010}: alu_op = ALU_SLT;
          default:         regwrite = 1'b0;
        endcase
      end
      OP_I: begin
        regwrite = 1'b1;
        alusrc   = 1'b1;
        case (funct3)
          3'b000:  alu_op = ALU_ADD;
          3'b010:  alu_op = ALU_SLT;
          3'b110:  alu_op = ALU_OR;
          3'b111:  alu_op = ALU_AND;
          default: regwrite = 1'b0;
        endcase
      end
      OP_BEQ: begin
        if (funct3 == 3'b000) begin
          branch  = 1'b1;
          alu_op  = ALU_SUB;
          imm_src = IMM_B;
        end
      end
      OP_JAL: begin
        regwrite   = 1'b1;
        jump       = 1'b1;
        imm_src    = IMM_J;
        result_src = RES_PC4;
      end
      default: ;
    endcase
  end

  // Sign-extended immediate for the instruction format in use.
  always_comb begin
    immext = 32'd0;
    case (imm_src)
      IMM_I: immext = {{20{instr[31]}}, instr[31:20]};
      IMM_S: immext = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B: immext = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_J: immext = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      default: immext = 32'd0;
    endcase
  end

  assign srca      = (rs1 == 5'd0) ? 32'd0 : rf[rs1];
  assign writedata = (rs2 == 5'd0) ? 32'd0 : rf[rs2];
  assign srcb      = alusrc ? immext : writedata;

  // ALU: wrap-around arithmetic, signed set-less-than.
  always_comb begin
    aluresult = srca + srcb;
    case (alu_op)
      ALU_ADD: aluresult = srca + srcb;
      ALU_SUB: aluresult = srca - srcb;
      ALU_AND: aluresult = srca & srcb;
      ALU_OR:  aluresult = srca | srcb;
      ALU_SLT: aluresult = {31'd0, $signed(srca) < $signed(srcb)};
      default: aluresult = srca + srcb;
    endcase
  end

  assign zero     = (aluresult == 32'd0);
  assign pcplus4  = pc + 32'd4;
  assign pctarget = pc + immext;
  assign pcnext   = (jump || (branch && zero)) ? pctarget : pcplus4;

  // Writeback source selection.
  always_comb begin
    result = aluresult;
    case (result_src)
      RES_ALU: result = aluresult;
      RES_MEM: result = readdata;
      RES_PC4: result = pcplus4;
      default: result = aluresult;
    endcase
  end

  // Program counter, cleared and held at 0 while reset is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pc <= 32'd0;
    else        pc <= pcnext;
  end

  // Register file write port; contents survive reset, x0 is never written.
  always_ff @(posedge clk) begin
    if (reset && regwrite && (rd != 5'd0)) rf[rd] <= result;
  end

endmodule

// File: rtl/riscv_sc_top.sv
// rtl/riscv_sc_top.sv - single-cycle RISC-V system: core, instruction ROM and data RAM
module riscv_sc_top
  import riscv_pkg::*;
#(
  parameter int    IMEM_WORDS = 64,
  parameter int    DMEM_WORDS = 64,
  parameter string IMEM_FILE  = "riscvtest.txt"
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] WriteData,
  output logic [31:0] DataAdr,
  output logic        MemWrite
);

  localparam int IAW = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;
  localparam int DAW = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;

  // The ROM image is named like the hex file it replaces and is built in at elaboration.
  localparam int PROG = (IMEM_FILE == "x0test.txt")  ? PROG_X0TEST  :
                        (IMEM_FILE == "slttest.txt") ? PROG_SLTTEST : PROG_RISCVTEST;

  logic [31:0]    pc, instr, readdata;
  logic [IAW-1:0] iidx;
  logic [DAW-1:0] didx;
  logic [31:0]    imem [IMEM_WORDS];
  logic [31:0]    dmem [DMEM_WORDS];

  for (genvar i = 0; i < IMEM_WORDS; i++) begin : g_rom
    assign imem[i] = rom_word(PROG, i);
  end

  assign iidx     = IAW'((pc >> 2) % 32'(IMEM_WORDS));
  assign instr    = imem[iidx];
  assign didx     = DAW'((DataAdr >> 2) % 32'(DMEM_WORDS));
  assign readdata = dmem[didx];

  riscv_core u_core (
    .clk       (clk),
    .reset     (reset),
    .instr     (instr),
    .readdata  (readdata),
    .pc        (pc),
    .memwrite  (MemWrite),
    .aluresult (DataAdr),
    .writedata (WriteData)
  );

  // Data RAM word write; suppressed while reset is held low.
  always_ff @(posedge clk) begin
    if (reset && MemWrite) dmem[didx] <= WriteData;
  end

endmodule

// File: tb/tb_riscv_sc_top.sv
// tb/tb_riscv_sc_top.sv - scoreboard bench for the single-cycle RISC-V system
module tb_riscv_sc_top;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] data;
  } st_t;

  logic        clk = 1'b0;
  logic        rst_main, rst_x0, rst_slt;
  logic [31:0] m_wd, m_adr, x_wd, x_adr, s_wd, s_adr;
  logic        m_mw, x_mw, s_mw;
  int          n_checks = 0;
  int          n_pass = 0;
  st_t         q_main[$];
  st_t         q_x0[$];
  st_t         q_slt[$];

  always #5 clk = ~clk;

  riscv_sc_top #(.IMEM_WORDS(64), .DMEM_WORDS(64), .IMEM_FILE("riscvtest.txt")) u_main (
    .clk(clk), .reset(rst_main), .WriteData(m_wd), .DataAdr(m_adr), .MemWrite(m_mw));
  riscv_sc_top #(.IMEM_WORDS(64), .DMEM_WORDS(64), .IMEM_FILE("x0test.txt")) u_x0 (
    .clk(clk), .reset(rst_x0), .WriteData(x_wd), .DataAdr(x_adr), .MemWrite(x_mw));
  riscv_sc_top #(.IMEM_WORDS(64), .DMEM_WORDS(64), .IMEM_FILE("slttest.txt")) u_slt (
    .clk(clk), .reset(rst_slt), .WriteData(s_wd), .DataAdr(s_adr), .MemWrite(s_mw));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic st_t mk(input logic [31:0] adr, input logic [31:0] data);
    st_t s;
    s.adr = adr;
    s.data = data;
    return s;
  endfunction

  // Store monitors: every store outside reset must match the head of its queue.
  always @(negedge clk) begin
    if (m_mw && !rst_main) check("main_mw_in_reset", {31'd0, m_mw}, 32'd0);
    else if (m_mw) begin
      if (q_main.size() == 0) check("main_extra_store", {31'd0, m_mw}, 32'd0);
      else begin
        st_t e;
        e = q_main.pop_front();
        check("main_st_adr", m_adr, e.adr);
        check("main_st_data", m_wd, e.data);
      end
    end
  end

  always @(negedge clk) begin
    if (x_mw && !rst_x0) check("x0_mw_in_reset", {31'd0, x_mw}, 32'd0);
    else if (x_mw) begin
      if (q_x0.size() == 0) check("x0_extra_store", {31'd0, x_mw}, 32'd0);
      else begin
        st_t e;
        e = q_x0.pop_front();
        check("x0_st_adr", x_adr, e.adr);
        check("x0_st_data", x_wd, e.data);
      end
    end
  end

  always @(negedge clk) begin
    if (s_mw && !rst_slt) check("slt_mw_in_reset", {31'd0, s_mw}, 32'd0);
    else if (s_mw) begin
      if (q_slt.size() == 0) check("slt_extra_store", {31'd0, s_mw}, 32'd0);
      else begin
        st_t e;
        e = q_slt.pop_front();
        check("slt_st_adr", s_adr, e.adr);
        check("slt_st_data", s_wd, e.data);
      end
    end
  end

  initial begin
    rst_main = 1'b0;
    rst_x0   = 1'b0;
    rst_slt  = 1'b0;
    q_main.push_back(mk(32'd96, 32'd7));
    q_main.push_back(mk(32'd100, 32'd25));
    q_x0.push_back(mk(32'd0, 32'd0));
    q_slt.push_back(mk(32'd8, 32'd1));

    @(negedge clk);
    check("rst_pc_main", u_main.u_core.pc, 32'd0);
    check("rst_pc_x0", u_x0.u_core.pc, 32'd0);
    check("rst_pc_slt", u_slt.u_core.pc, 32'd0);
    check("rst_mw_main", {31'd0, m_mw}, 32'd0);
    @(negedge clk);
    check("rst_pc_main_2", u_main.u_core.pc, 32'd0);
    check("rst_mw_x0", {31'd0, x_mw}, 32'd0);
    check("rst_mw_slt", {31'd0, s_mw}, 32'd0);
    #2;
    rst_main = 1'b1;
    rst_x0   = 1'b1;
    rst_slt  = 1'b1;

    for (int i = 0; i < 100 && (q_main.size() + q_x0.size() + q_slt.size()) != 0; i++)
      @(negedge clk);
    check("run1_main_left", q_main.size(), 32'd0);
    check("run1_x0_left", q_x0.size(), 32'd0);
    check("run1_slt_left", q_slt.size(), 32'd0);
    repeat (5) @(negedge clk);
    check("main_pc_loop", u_main.u_core.pc, 32'h50);
    check("x0_pc_loop", u_x0.u_core.pc, 32'h8);
    check("slt_pc_loop", u_slt.u_core.pc, 32'hC);
    @(negedge clk);
    check("main_pc_loop_2", u_main.u_core.pc, 32'h50);

    // Restart, then interrupt right after the first store.
    #1 rst_main = 1'b0;
    #1 check("rerst_pc_async", u_main.u_core.pc, 32'd0);
    q_main.push_back(mk(32'd96, 32'd7));
    @(negedge clk);
    check("rerst_pc_held", u_main.u_core.pc, 32'd0);
    #2 rst_main = 1'b1;
    for (int i = 0; i < 60 && q_main.size() != 0; i++) @(negedge clk);
    check("run2_first_store_seen", q_main.size(), 32'd0);
    #1 rst_main = 1'b0;
    #1 check("midrst_pc", u_main.u_core.pc, 32'd0);
    q_main.push_back(mk(32'd96, 32'd7));
    q_main.push_back(mk(32'd100, 32'd25));
    @(negedge clk);
    check("midrst_pc_held", u_main.u_core.pc, 32'd0);
    #2 rst_main = 1'b1;
    for (int i = 0; i < 100 && q_main.size() != 0; i++) @(negedge clk);
    check("run3_main_left", q_main.size(), 32'd0);
    repeat (5) @(negedge clk);
    check("run3_pc_loop", u_main.u_core.pc, 32'h50);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
